cell_pixel_writer: RTL and testbench

- Consumer end of the grid cell-update stream produced by the frame scanner. It accepts changed-cell records (x, y, obj_code, diff) and buffers them in a small FIFO.
- Each record is expanded into a CELL_W x CELL_H block of RGB565 pixel writes on a valid/ready pixel stream that feeds the display controller.
- Lets the scanner run at its own rate while the display side applies backpressure.

---
 rtl/cell_pixel_writer.sv | 153 +++++++++++++++
 tb/tb_cell_pixel_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cell_pixel_writer.sv
// Expands buffered grid cell-update records into CELL_W x CELL_H blocks of
// RGB565 pixel writes on a valid/ready stream toward the display controller.
module cell_pixel_writer #(
    parameter int CELL_W     = 20,
    parameter int CELL_H     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        diff,
    input  logic [3:0]  x,
    input  logic [3:0]  y,
    input  logic [2:0]  obj_code,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [8:0]  px_x,
    output logic [7:0]  px_y,
    output logic [15:0] color,
    output logic        px_last,
    output logic        busy,
    output logic        overflow,
    output logic [2:0]  fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int COL_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int ROW_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DRAW = 1'b1;

    // Pixel stream handshake: a pixel transfers on a rising edge where
    // px_valid && px_ready; while px_valid is high and px_ready is low the
    // pixel fields hold, and px_valid never drops until the transfer occurs.

    logic [0:0]       state;
    logic [3:0]       fifo_x    [FIFO_DEPTH];
    logic [3:0]       fifo_y    [FIFO_DEPTH];
    logic [2:0]       fifo_code [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [8:0]       base_x;
    logic [7:0]       base_y;

    logic rec_ok;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic col_end;
    logic row_end;
    logic handshake;

    function automatic logic [15:0] code_color(input logic [2:0] code);
        logic [15:0] c;
        case (code)
            3'b001:  c = 16'h07E0;
            3'b010:  c = 16'h03E0;
            3'b011:  c = 16'hF800;
            3'b100:  c = 16'h8410;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Rows 12..15 lie off-screen and are discarded without flagging overflow.
    assign rec_ok    = diff && (y <= 4'd11);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = (state == S_IDLE) && (count != '0);
    assign push      = rec_ok && (!full || pop);
    assign drop      = rec_ok && full && !pop;
    assign col_end   = (col == COL_W'(CELL_W - 1));
    assign row_end   = (row == ROW_W'(CELL_H - 1));
    assign handshake = (state == S_DRAW) && px_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wptr]    <= x;
            fifo_y[wptr]    <= y;
            fifo_code[wptr] <= obj_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            col    <= '0;
            row    <= '0;
            base_x <= '0;
            base_y <= '0;
            color  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        base_x <= 9'(fifo_x[rptr]) * 9'(CELL_W);
                        base_y <= 8'(fifo_y[rptr]) * 8'(CELL_H);
                        color  <= code_color(fifo_code[rptr]);
                        col    <= '0;
                        row    <= '0;
                        state  <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (handshake) begin
                        if (col_end) begin
                            col <= '0;
                            if (row_end) begin
                                row   <= '0;
                                state <= S_IDLE;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign px_valid   = (state == S_DRAW);
    assign px_x       = base_x + 9'(col);
    assign px_y       = base_y + 8'(row);
    assign px_last    = (state == S_DRAW) && col_end && row_end;
    assign busy       = (count != '0) || (state == S_DRAW);
    assign fifo_count = 3'(count);

endmodule

// File: tb/tb_cell_pixel_writer.sv
// Scoreboard bench for cell_pixel_writer: expected pixels are queued when a
// record is driven and compared as the DUT hands pixels over.
module tb_cell_pixel_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        diff = 1'b0;
    logic [3:0]  x = '0;
    logic [3:0]  y = '0;
    logic [2:0]  obj_code = '0;
    logic        px_valid;
    logic        px_ready = 1'b0;
    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic [15:0] color;
    logic        px_last;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    logic [33:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          hs_count = 0;
    logic        stall_pend = 1'b0;
    logic [33:0] stall_val = '0;

    cell_pixel_writer dut (
        .clk(clk), .rst(rst), .diff(diff), .x(x), .y(y), .obj_code(obj_code),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
        .color(color), .px_last(px_last), .busy(busy), .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_color(input logic [2:0] code);
        case (code)
            3'd1:    return 16'h07E0;
            3'd2:    return 16'h03E0;
            3'd3:    return 16'hF800;
            3'd4:    return 16'h8410;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push_block(input int cx, input int cy, input logic [2:0] code);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++)
                exp_q.push_back({9'(cx * 20 + c), 8'(cy * 20 + r), ref_color(code),
                                 (r == 19 && c == 19)});
    endtask

    // Monitor samples at the falling edge; a valid&&ready seen here transfers
    // at the following rising edge.
    always @(negedge clk) begin
        if (stall_pend) begin
            check("stall_valid", {63'b0, px_valid}, 64'd1);
            check("stall_hold", {30'b0, px_x, px_y, color, px_last}, {30'b0, stall_val});
        end
        if (!rst && px_valid && px_ready) begin
            hs_count++;
            if (exp_q.size() != 0)
                check("pixel", {30'b0, px_x, px_y, color, px_last}, {30'b0, exp_q.pop_front()});
            else
                check("no_px", {63'b0, px_valid}, 64'd0);
        end
        stall_pend = !rst && px_valid && !px_ready;
        stall_val  = {px_x, px_y, color, px_last};
    end

    task automatic do_reset();
        rst = 1'b1;
        diff = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    // Drives one record for one cycle; returns 1 time unit after the sampling edge.
    task automatic send_record(input int cx, input int cy, input logic [2:0] code,
                               input bit accept);
        x = 4'(cx);
        y = 4'(cy);
        obj_code = code;
        diff = 1'b1;
        if (accept) push_block(cx, cy, code);
        @(posedge clk);
        #1;
        diff = 1'b0;
    endtask

    task automatic wait_drain(input bit toggle, output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || busy) && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (toggle) px_ready = ~px_ready;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int base;

        // Test 1: single block, reset values and latency
        do_reset();
        check("rst_valid", {63'b0, px_valid}, 64'd0);
        check("rst_pos", {47'b0, px_x, px_y}, 64'd0);
        check("rst_color", {48'b0, color}, 64'd0);
        check("rst_flags", {58'b0, px_last, busy, overflow, fifo_count}, 64'd0);
        px_ready = 1'b1;
        base = hs_count;
        send_record(3, 2, 3'b011, 1'b1);
        check("lat_idle", {63'b0, px_valid}, 64'd0);
        check("lat_count", {61'b0, fifo_count}, 64'd1);
        check("lat_busy", {63'b0, busy}, 64'd1);
        @(posedge clk);
        #1;
        check("lat_valid", {63'b0, px_valid}, 64'd1);
        check("first_px", {47'b0, px_x, px_y}, {47'b0, 9'd60, 8'd40});
        wait_drain(1'b0, cyc);
        check("t1_cycles", 64'(cyc), 64'd400);
        check("t1_hs", 64'(hs_count - base), 64'd400);
        check("t1_busy", {63'b0, busy}, 64'd0);
        check("t1_ovf", {63'b0, overflow}, 64'd0);

        // Test 2: corner cell with px_ready toggling every cycle
        px_ready = 1'b0;
        base = hs_count;
        send_record(15, 11, 3'b100, 1'b1);
        wait_drain(1'b1, cyc);
        check("t2_hs", 64'(hs_count - base), 64'd400);

        // Test 3: fill FIFO under backpressure, sixth record overflows
        px_ready = 1'b0;
        @(posedge clk);
        #1;
        base = hs_count;
        for (int i = 0; i < 6; i++) send_record(i, 0, 3'b001, i < 5);
        check("t3_count", {61'b0, fifo_count}, 64'd4);
        check("t3_ovf", {63'b0, overflow}, 64'd1);
        check("t3_valid", {63'b0, px_valid}, 64'd1);
        px_ready = 1'b1;
        wait_drain(1'b0, cyc);
        check("t3_hs", 64'(hs_count - base), 64'd2000);
        check("t3_ovf_sticky", {63'b0, overflow}, 64'd1);

        // Test 4: off-screen row is discarded silently
        do_reset();
        check("t4_ovf_clr", {63'b0, overflow}, 64'd0);
        send_record(2, 13, 3'b001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_count", {61'b0, fifo_count}, 64'd0);
        check("t4_valid", {63'b0, px_valid}, 64'd0);
        check("t4_ovf", {63'b0, overflow}, 64'd0);

        // Test 5: reset mid-block with two records queued
        px_ready = 1'b1;
        base = hs_count;
        for (int i = 0; i < 3; i++) send_record(2 + i, 5, 3'b010, 1'b1);
        cyc = 0;
        while (hs_count - base < 50 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t5_hs50", 64'(hs_count - base), 64'd50);
        check("t5_queued", {61'b0, fifo_count}, 64'd2);
        px_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t5_valid", {63'b0, px_valid}, 64'd0);
        check("t5_count", {61'b0, fifo_count}, 64'd0);
        check("t5_busy", {63'b0, busy}, 64'd0);
        rst = 1'b0;
        px_ready = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        check("t5_no_more", 64'(hs_count - base), 64'd50);

        // Test 6: unused object code maps to black
        base = hs_count;
        send_record(1, 1, 3'b111, 1'b1);
        wait_drain(1'b0, cyc);
        check("t6_hs", 64'(hs_count - base), 64'd400);

        // Random records with random backpressure, fed one at a time
        for (int k = 0; k < 4; k++) begin
            int rx;
            int ry;
            rx = int'($urandom_range(0, 15));
            ry = int'($urandom_range(0, 11));
            base = hs_count;
            px_ready = 1'($urandom_range(0, 1));
            send_record(rx, ry, 3'($urandom_range(0, 7)), 1'b1);
            wait_drain(1'b1, cyc);
            check("rand_hs", 64'(hs_count - base), 64'd400);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
